// File: rtl/meter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | meter_pkg                                                                |
// | Shared definitions for the period meter: FSM state encoding and the      |
// | default field width / timeout values.                                    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package meter_pkg;

    localparam int unsigned DEFAULT_WIDTH   = 32;
    localparam int unsigned DEFAULT_TIMEOUT = 100000000;
    localparam int unsigned STATE_W         = 2;

    // IDLE waits for the first rising edge; the two measuring states track
    // the current level of the synchronized signal while counting.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE         = 2'd0,
        ST_MEASURE_HIGH = 2'd1,
        ST_MEASURE_LOW  = 2'd2
    } meter_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sync_edge                                                                |
// | Two-flop synchronizer followed by an edge register. Emits one-cycle      |
// | rise/fall pulses for an asynchronous input.                              |
// | Ports: clk_in  - sampling clock                                          |
// |        rst_n   - asynchronous active-low reset (flops cleared to 0)      |
// |        d       - asynchronous input                                      |
// |        rise    - one-cycle pulse on a 0->1 transition of d               |
// |        fall    - one-cycle pulse on a 1->0 transition of d               |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module sync_edge (
    input  logic clk_in,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= d;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Pulses are valid during the cycle that follows the second synchronizer
    // stage updating, so the consumer acts on them at the third clock edge
    // after the input transition.
    assign rise = r_sync2 & ~r_prev;
    assign fall = ~r_sync2 & r_prev;

endmodule
`default_nettype wire

// File: rtl/period_meter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | period_meter                                                             |
// | Measures the period and high time of an asynchronous signal in clk_in    |
// | cycles, presenting each result through a valid/ready handshake.          |
// | Parameters: WIDTH   - width of count and result fields                   |
// |             TIMEOUT - max cycles between edges before aborting           |
// |                       (must be below 2**WIDTH)                           |
// | Ports: clk_in       - system clock                                       |
// |        rst_n        - asynchronous active-low reset                      |
// |        sig_in       - measured signal, asynchronous to clk_in            |
// |        period_out   - cycles between two consecutive rising edges        |
// |        high_out     - cycles sig_in was high within that period          |
// |        result_valid - period_out/high_out hold an unconsumed result      |
// |        result_ready - consumer accepts the result                        |
// |        overrun      - a result was overwritten before acceptance         |
// |        timeout      - no required edge arrived within TIMEOUT cycles     |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module period_meter
    import meter_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period_out,
    output logic [WIDTH-1:0] high_out,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             overrun,
    output logic             timeout
);

    localparam logic [WIDTH-1:0] C_TIMEOUT = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] C_ONE     = WIDTH'(1);

    // ------------------------------------------------------------------
    // Synchronizer / edge detector
    // ------------------------------------------------------------------
    logic w_rise;
    logic w_fall;

    sync_edge u_sync_edge (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .d      (sig_in),
        .rise   (w_rise),
        .fall   (w_fall)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    meter_state_e     r_state;
    meter_state_e     w_state_next;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_high_cnt;
    logic             w_at_limit;
    logic             w_start;
    logic             w_latch_high;
    logic             w_new_result;
    logic             w_timeout_evt;

    assign w_at_limit = (r_count == C_TIMEOUT);

    // State register
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. The expected edge takes priority over the limit so
    // that a period of exactly TIMEOUT cycles still yields a result.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_next = ST_MEASURE_HIGH;
                end
            end
            ST_MEASURE_HIGH: begin
                if (w_fall) begin
                    w_state_next = ST_MEASURE_LOW;
                end else if (w_at_limit) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_MEASURE_LOW: begin
                if (w_rise) begin
                    w_state_next = ST_MEASURE_HIGH;
                end else if (w_at_limit) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Output / control decode
    always_comb begin
        w_start       = 1'b0;
        w_latch_high  = 1'b0;
        w_new_result  = 1'b0;
        w_timeout_evt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_start = w_rise;
            end
            ST_MEASURE_HIGH: begin
                w_latch_high  = w_fall;
                w_timeout_evt = ~w_fall & w_at_limit;
            end
            ST_MEASURE_LOW: begin
                // A rise closes the current period and opens the next one
                // in the same cycle, so there is no dead cycle.
                w_new_result  = w_rise;
                w_start       = w_rise;
                w_timeout_evt = ~w_rise & w_at_limit;
            end
            default: begin
                w_start = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_start) begin
            r_count <= C_ONE;
        end else if (w_timeout_evt) begin
            r_count <= '0;
        end else if ((r_state != ST_IDLE) && !w_at_limit) begin
            // Saturates at the limit; the count never wraps.
            r_count <= r_count + C_ONE;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_high_cnt <= '0;
        end else if (w_latch_high) begin
            r_high_cnt <= r_count;
        end
    end

    // ------------------------------------------------------------------
    // Result registers and handshake
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_high;
    logic             r_valid;
    logic             r_overrun;
    logic             r_timeout;
    logic             w_accept;

    assign w_accept = r_valid & result_ready;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_period  <= '0;
            r_high    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_new_result) begin
            r_period <= r_count;
            r_high   <= r_high_cnt;
            r_valid  <= 1'b1;
            // A result coinciding with a handshake replaces the accepted
            // one cleanly; only an unaccepted one counts as an overrun.
            if (r_valid && !result_ready) begin
                r_overrun <= 1'b1;
            end
        end else if (w_accept) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    // Timeout stays set until the next result is loaded; the result
    // registers are deliberately untouched by a timeout.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_timeout <= 1'b0;
        end else if (w_timeout_evt) begin
            r_timeout <= 1'b1;
        end else if (w_new_result) begin
            r_timeout <= 1'b0;
        end
    end

    assign period_out   = r_period;
    assign high_out     = r_high;
    assign result_valid = r_valid;
    assign overrun      = r_overrun;
    assign timeout      = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_period_meter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_period_meter                                                          |
// | Self-checking bench for period_meter. Expected results are derived from  |
// | the driven rising/falling edge times of sig_in.                          |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_period_meter;

    localparam int W  = 16;
    localparam int TO = 64;

    logic         clk_in       = 1'b0;
    logic         rst_n        = 1'b0;
    logic         sig_in       = 1'b0;
    logic         result_ready = 1'b0;
    logic [W-1:0] period_out;
    logic [W-1:0] high_out;
    logic         result_valid;
    logic         overrun;
    logic         timeout;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0] p;
        logic [W-1:0] h;
        logic         ov;
    } res_t;

    res_t obs_q[$];
    res_t exp_q[$];
    int   tr_h[$];
    int   tr_l[$];

    period_meter #(
        .WIDTH   (W),
        .TIMEOUT (TO)
    ) dut (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .sig_in       (sig_in),
        .period_out   (period_out),
        .high_out     (high_out),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .overrun      (overrun),
        .timeout      (timeout)
    );

    always #5 clk_in = ~clk_in;

    // Record every accepted result (inputs change just after posedge, so the
    // negedge sees what the next posedge will act on).
    always @(negedge clk_in) begin
        if (result_valid === 1'b1 && result_ready === 1'b1) begin
            obs_q.push_back({period_out, high_out, overrun});
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic apply_reset();
        rst_n        = 1'b0;
        sig_in       = 1'b0;
        result_ready = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        obs_q.delete();
    endtask

    task automatic wave(input int h, input int l);
        sig_in = 1'b1;
        tick(h);
        sig_in = 1'b0;
        tick(l);
    endtask

    // Drives the (high, low) train in tr_h/tr_l followed by a closing rise.
    // Each rise-to-rise interval of at most TO cycles is a result; a longer
    // one aborts and the following rise starts afresh.
    task automatic run_train(input string tag);
        bit last_to;
        exp_q.delete();
        apply_reset();
        result_ready = 1'b1;
        last_to      = 1'b0;
        for (int i = 0; i < tr_h.size(); i++) begin
            int p;
            p = tr_h[i] + tr_l[i];
            if (p <= TO) begin
                exp_q.push_back({W'(p), W'(tr_h[i]), 1'b0});
                last_to = 1'b0;
            end else begin
                last_to = 1'b1;
            end
            wave(tr_h[i], tr_l[i]);
        end
        sig_in = 1'b1;
        tick(6);
        check({tag, " count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check({tag, " period"}, obs_q[i].p, exp_q[i].p);
            check({tag, " high"}, obs_q[i].h, exp_q[i].h);
            check({tag, " overrun"}, obs_q[i].ov, exp_q[i].ov);
        end
        check({tag, " timeout"}, timeout, last_to);
        check({tag, " valid"}, result_valid, 0);
        sig_in = 1'b0;
    endtask

    initial begin
        int pp;
        int ph;
        int jr;
        int n_ok;

        // ---------------- reset state ----------------
        tick(2);
        check("rst valid", result_valid, 0);
        check("rst period", period_out, 0);
        check("rst high", high_out, 0);
        check("rst overrun", overrun, 0);
        check("rst timeout", timeout, 0);

        // ---------------- 10-cycle square wave, 5 high ----------------
        tr_h.delete(); tr_l.delete();
        repeat (5) begin tr_h.push_back(5); tr_l.push_back(5); end
        run_train("sq10");

        // ---------------- limit boundary: 64 ok, 65 aborts ----------------
        tr_h.delete(); tr_l.delete();
        tr_h.push_back(30); tr_l.push_back(34);
        tr_h.push_back(30); tr_l.push_back(35);
        tr_h.push_back(10); tr_l.push_back(10);
        run_train("limit");

        // ---------------- random trains ----------------
        repeat (2) begin
            tr_h.delete(); tr_l.delete();
            repeat (10) begin
                tr_h.push_back($urandom_range(2, 30));
                tr_l.push_back($urandom_range(2, 45));
            end
            run_train("rand");
        end

        // ---------------- overrun: 12-cycle period, 3 high ----------------
        apply_reset();
        wave(3, 9);
        wave(3, 9);
        sig_in = 1'b1;
        tick(6);
        check("ovr valid", result_valid, 1);
        check("ovr period", period_out, 12);
        check("ovr high", high_out, 3);
        check("ovr flag", overrun, 1);
        result_ready = 1'b1;
        tick(1);
        result_ready = 1'b0;
        check("ovr hs count", obs_q.size(), 1);
        if (obs_q.size() > 0) check("ovr hs flag", obs_q[0].ov, 1);
        check("ovr cleared valid", result_valid, 0);
        check("ovr cleared flag", overrun, 0);
        sig_in = 1'b0;

        // ---------------- result coinciding with handshake ----------------
        apply_reset();
        wave(4, 6);
        wave(7, 8);
        sig_in = 1'b1;
        tick(2);
        check("coin pre valid", result_valid, 1);
        check("coin pre period", period_out, 10);
        result_ready = 1'b1;
        tick(1);
        result_ready = 1'b0;
        check("coin valid", result_valid, 1);
        check("coin period", period_out, 15);
        check("coin high", high_out, 7);
        check("coin overrun", overrun, 0);
        check("coin hs count", obs_q.size(), 1);
        if (obs_q.size() > 0) check("coin hs period", obs_q[0].p, 10);
        sig_in = 1'b0;

        // ---------------- timeout with sig_in stuck high ----------------
        apply_reset();
        wave(5, 5);
        sig_in = 1'b1;
        // The rise is acted on 3 cycles after it is driven (count = 1);
        // count reaches TO after TO-1 more cycles, flag visible one later.
        tick(TO + 2);
        check("to early", timeout, 0);
        check("to early valid", result_valid, 1);
        tick(1);
        check("to flag", timeout, 1);
        check("to held valid", result_valid, 1);
        check("to held period", period_out, 10);
        check("to held high", high_out, 5);
        result_ready = 1'b1;
        tick(1);
        sig_in = 1'b0;
        tick(4);
        sig_in = 1'b1;
        tick(8);
        check("to sticky", timeout, 1);
        sig_in = 1'b0;
        tick(12);
        sig_in = 1'b1;
        tick(6);
        check("to cleared", timeout, 0);
        check("to result count", obs_q.size(), 2);
        if (obs_q.size() > 1) begin
            check("to new period", obs_q[1].p, 20);
            check("to new high", obs_q[1].h, 8);
        end
        sig_in = 1'b0;

        // ---------------- reset mid-period ----------------
        apply_reset();
        wave(6, 4);
        sig_in = 1'b1;
        tick(3);
        sig_in = 1'b0;
        tick(2);
        check("mid pre valid", result_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid rst valid", result_valid, 0);
        check("mid rst period", period_out, 0);
        check("mid rst high", high_out, 0);
        check("mid rst overrun", overrun, 0);
        check("mid rst timeout", timeout, 0);
        tick(2);
        rst_n        = 1'b1;
        result_ready = 1'b1;
        obs_q.delete();
        wave(7, 9);
        wave(7, 9);
        sig_in = 1'b1;
        tick(6);
        check("mid count", obs_q.size(), 2);
        for (int i = 0; i < obs_q.size(); i++) begin
            check("mid period", obs_q[i].p, 16);
            check("mid high", obs_q[i].h, 7);
        end
        sig_in = 1'b0;

        // ---------------- random phase offset ----------------
        apply_reset();
        result_ready = 1'b1;
        pp = $urandom_range(10, 30);
        ph = pp / 2;
        #($urandom_range(0, 9));
        for (int i = 0; i < 9; i++) begin
            jr = $urandom_range(0, 9);
            #(jr);
            sig_in = 1'b1;
            #(ph * 10);
            sig_in = 1'b0;
            #((pp - ph) * 10 - jr);
        end
        #($urandom_range(0, 9));
        sig_in = 1'b1;
        tick(6);
        check("phase count", obs_q.size(), 9);
        n_ok = 0;
        for (int i = 0; i < obs_q.size(); i++) begin
            if (int'(obs_q[i].p) >= pp - 1 && int'(obs_q[i].p) <= pp + 1 &&
                int'(obs_q[i].h) >= ph - 1 && int'(obs_q[i].h) <= ph + 1) begin
                n_ok++;
            end
        end
        check("phase within 1", n_ok, obs_q.size());
        sig_in = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the width of the count and result fields.
REQ-002 SHALL have parameter TIMEOUT, default 100000000, giving the maximum clk_in cycles allowed between rising edges before measurement aborts.
REQ-003 SHALL have port clk_in  input  1  single system clock, all logic on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port sig_in  input  1  measured signal, asynchronous to clk_in (e.g. a divided clock).
REQ-006 SHALL have port period_out  output  WIDTH  clk_in cycles between two consecutive rising edges of sig_in.
REQ-007 SHALL have port high_out  output  WIDTH  clk_in cycles sig_in was high within that period.
REQ-008 SHALL have port result_valid  output  1  period_out/high_out hold an unconsumed result.
REQ-009 SHALL have port result_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port overrun  output  1  a result was overwritten before acceptance.
REQ-011 SHALL have port timeout  output  1  no rising edge arrived within TIMEOUT cycles.

Function
REQ-012 SHALL pass sig_in through a 2-flop synchronizer plus an edge register, producing single-cycle rise/fall pulses 3 clk_in cycles after the sig_in transition.
REQ-013 SHALL implement the FSM states IDLE (wait for first rise), MEASURE_HIGH (counting, sig high) and MEASURE_LOW (counting, sig low).
REQ-014 SHALL transition IDLE->MEASURE_HIGH on a rise pulse, loading count=1.
REQ-015 SHALL increment count every cycle in MEASURE_HIGH/MEASURE_LOW, and on a fall pulse in MEASURE_HIGH latch high_cnt=count and go to MEASURE_LOW.
REQ-016 SHALL, on a rise pulse in MEASURE_LOW, load period_out=count and high_out=high_cnt, assert result_valid the next cycle, reload count=1 and enter MEASURE_HIGH, with no dead cycle between periods.
REQ-017 SHALL clear result_valid in the cycle after result_valid and result_ready are both high.
REQ-018 SHALL, on a new result while result_valid is high and not being accepted that cycle, overwrite both outputs with the new result, keep result_valid high, and set overrun.
REQ-019 SHALL treat a new result arriving in the same cycle as a handshake as a normal result, leaving result_valid high and overrun unchanged.
REQ-020 SHALL keep overrun sticky until the next completed handshake.
REQ-021 SHALL, when count reaches TIMEOUT in either measuring state without the required edge, go to IDLE, set timeout, clear count, and produce no result.
REQ-022 SHALL keep timeout sticky until the next new result is loaded.
REQ-023 SHALL hold existing period_out/high_out/result_valid across a timeout.
REQ-024 SHALL saturate count at TIMEOUT, since count never wraps.
REQ-025 SHALL require TIMEOUT < 2^WIDTH.
REQ-026 SHALL ignore a fall pulse in IDLE or MEASURE_LOW, and a rise pulse in MEASURE_HIGH, which cannot occur after synchronization.

Reset
REQ-027 SHALL, on rst_n low, asynchronously force FSM=IDLE, count=0, high_cnt=0, period_out=0, high_out=0, result_valid=0, overrun=0, timeout=0 and clear the synchronizer flops to 0.
REQ-028 SHALL, on reset mid-measurement, discard the partial count, and the first rise pulse after release SHALL start a fresh measurement.

Structure
REQ-029 SHALL place the FSM state enumeration and the default WIDTH/TIMEOUT constants in shared package meter_pkg.
REQ-030 SHALL implement the synchronizer and edge detector as sub-module sync_edge (ports clk_in, rst_n, d, rise, fall), reusable elsewhere in the codebase.

Verification
REQ-031 SHALL cover: sig_in square wave with 10-cycle period, 5 high, result_ready=1 -> every result period_out=10, high_out=5, overrun=0.
REQ-032 SHALL cover: 12-cycle period, 3 high, result_ready=0 for two periods -> the second result overwrites with period_out=12, high_out=3, overrun=1, cleared after handshake.
REQ-033 SHALL cover: TIMEOUT=64, sig_in stuck high after one rise -> timeout=1 at count 64, FSM=IDLE; the next full period of 20 clears timeout and gives period_out=20.
REQ-034 SHALL cover: rst_n pulsed low mid-period -> all outputs 0 immediately; the first result after release is correct and not partial.
REQ-035 SHALL cover: a new result coinciding with a handshake cycle -> result_valid stays 1, new values presented, overrun stays 0.
REQ-036 SHALL cover: sig_in driven with random phase offset relative to clk_in -> period_out within +/-1 of the nominal period.
